// File: rtl/m_ext_unit_if.sv
// Request/response bundle for the M-extension multiply/divide unit.
// master drives the request side, slave is the arithmetic unit.
interface m_ext_unit_if #(parameter int WIDTH = 32);
  logic             ip_start;
  logic             ip_kill;
  logic [2:0]       ip_funct_3;
  logic [WIDTH-1:0] ip_operand_a;
  logic [WIDTH-1:0] ip_operand_b;
  logic             op_busy;
  logic             op_done;
  logic [WIDTH-1:0] op_result;

  modport master (
    output ip_start, ip_kill, ip_funct_3, ip_operand_a, ip_operand_b,
    input  op_busy, op_done, op_result
  );

  modport slave (
    input  ip_start, ip_kill, ip_funct_3, ip_operand_a, ip_operand_b,
    output op_busy, op_done, op_result
  );
endinterface

// File: rtl/m_ext_unit.sv
// Iterative RV32M multiply/divide: radix-2, op_done 32 cycles after start (2 for div-by-zero/overflow).
// No backpressure: start is taken only in IDLE and ignored while busy; kill aborts an iteration in flight.
module m_ext_unit #(
  parameter int WIDTH = 32
) (
  input logic        ip_clk,
  input logic        ip_rst_n,
  m_ext_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [2:0]       funct_q;
  logic             neg_q, rneg_q, fast_q, busy_q, done_q;
  logic [WIDTH-1:0] hi_q, lo_q, op_q, fast_res_q, result_q;

  logic [2:0]       f;
  logic [WIDTH-1:0] a, b, mag_a, mag_b, fast_val;
  logic             a_sgn, b_sgn, neg_a, neg_b, is_div, div_zero, div_ovf;

  assign f = bus.ip_funct_3;
  assign a = bus.ip_operand_a;
  assign b = bus.ip_operand_b;

  always_comb begin
    a_sgn    = (f == 3'b001) || (f == 3'b010) || (f == 3'b100) || (f == 3'b110);
    b_sgn    = (f == 3'b001) || (f == 3'b100) || (f == 3'b110);
    neg_a    = a_sgn & a[WIDTH-1];
    neg_b    = b_sgn & b[WIDTH-1];
    mag_a    = neg_a ? -a : a;
    mag_b    = neg_b ? -b : b;
    is_div   = f[2];
    div_zero = is_div && (b == '0);
    div_ovf  = is_div && !f[0] && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    fast_val = '0;
    if (div_zero)
      fast_val = f[1] ? a : '1;
    else if (div_ovf)
      fast_val = f[1] ? '0 : a;
  end

  // One radix-2 step. The first step runs on the start edge straight from the
  // operand magnitudes, so the 32nd lands on the edge that enters DONE.
  logic [WIDTH-1:0] s_hi, s_lo, s_op, n_hi, n_lo;
  logic             s_div;
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;

  always_comb begin
    s_hi  = '0;
    s_lo  = is_div ? mag_a : mag_b;
    s_op  = is_div ? mag_b : mag_a;
    s_div = is_div;
    if (state != S_IDLE) begin
      s_hi  = hi_q;
      s_lo  = lo_q;
      s_op  = op_q;
      s_div = (state == S_DIV);
    end
    mul_sum  = {1'b0, s_hi} + {1'b0, (s_lo[0] ? s_op : {WIDTH{1'b0}})};
    div_sh   = {s_hi, s_lo[WIDTH-1]};
    div_diff = div_sh - {1'b0, s_op};
    n_hi     = mul_sum[WIDTH:1];
    n_lo     = {mul_sum[0], s_lo[WIDTH-1:1]};
    if (s_div) begin
      if (!div_diff[WIDTH]) begin
        n_hi = div_diff[WIDTH-1:0];
        n_lo = {s_lo[WIDTH-2:0], 1'b1};
      end else begin
        n_hi = div_sh[WIDTH-1:0];
        n_lo = {s_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, fin;

  always_comb begin
    prod = {n_hi, n_lo};
    if (neg_q)
      prod = -prod;
    quo = neg_q ? -n_lo : n_lo;
    rem = rneg_q ? -n_hi : n_hi;
    case (funct_q)
      3'b000:                 fin = prod[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fin = prod[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fin = quo;
      default:                fin = rem;
    endcase
  end

  always_ff @(posedge ip_clk or negedge ip_rst_n) begin
    if (!ip_rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      funct_q    <= '0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      fast_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      op_q       <= '0;
      fast_res_q <= '0;
      result_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.ip_start && !bus.ip_kill) begin
            state      <= is_div ? S_DIV : S_MUL;
            busy_q     <= 1'b1;
            cnt        <= '0;
            funct_q    <= f;
            neg_q      <= neg_a ^ neg_b;
            rneg_q     <= neg_a;
            fast_q     <= div_zero || div_ovf;
            fast_res_q <= fast_val;
            hi_q       <= n_hi;
            lo_q       <= n_lo;
            op_q       <= s_op;
          end
        end
        S_MUL, S_DIV: begin
          if (bus.ip_kill) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end else if (fast_q) begin
            state    <= S_DONE;
            done_q   <= 1'b1;
            result_q <= fast_res_q;
          end else begin
            hi_q <= n_hi;
            lo_q <= n_lo;
            cnt  <= cnt + 1'b1;
            if (cnt == CW'(WIDTH-2)) begin
              state    <= S_DONE;
              done_q   <= 1'b1;
              result_q <= fin;
            end
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.op_busy   = busy_q;
  assign bus.op_done   = done_q;
  assign bus.op_result = result_q;
endmodule

// File: tb/tb_m_ext_unit.sv
// Directed bench for m_ext_unit: hand-computed results, latencies, kill and reset behaviour.
module tb_m_ext_unit;
  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  logic ip_clk;
  logic ip_rst_n;
  int   n_chk;
  int   n_fail;

  m_ext_unit_if #(.WIDTH(32)) bus ();

  m_ext_unit #(.WIDTH(32)) dut (
    .ip_clk   (ip_clk),
    .ip_rst_n (ip_rst_n),
    .bus      (bus)
  );

  initial ip_clk = 1'b0;
  always #5 ip_clk = ~ip_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge ip_clk);
    #1;
  endtask

  // Called 1ns after an edge; returns 1ns after the start edge (cycle 1).
  task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.ip_funct_3   = f;
    bus.ip_operand_a = a;
    bus.ip_operand_b = b;
    bus.ip_start     = 1'b1;
    step();
    bus.ip_start     = 1'b0;
    bus.ip_operand_a = ~a;
    bus.ip_operand_b = b + 32'd3;
    bus.ip_funct_3   = ~f;
  endtask

  // inj > 0 re-raises start with new operands in that cycle, which must be ignored.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_cyc,
                        input int inj);
    int cyc;
    int nb;
    start_op(f, a, b);
    cyc = 1;
    nb  = 0;
    while (!bus.op_done && cyc < 40) begin
      if (bus.op_busy) nb++;
      if (cyc == inj) begin
        bus.ip_start     = 1'b1;
        bus.ip_operand_a = 32'd100;
        bus.ip_operand_b = 32'd100;
      end else begin
        bus.ip_start = 1'b0;
      end
      step();
      cyc++;
    end
    bus.ip_start = 1'b0;
    if (bus.op_busy) nb++;
    chk({tag, " latency"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, " result"}, 64'(bus.op_result), 64'(exp_res));
    chk({tag, " busy cycles"}, 64'(nb), 64'(exp_cyc));
    step();
    chk({tag, " idle after done"}, {62'd0, bus.op_busy, bus.op_done}, 64'd0);
  endtask

  initial begin
    int nd;
    n_chk            = 0;
    n_fail           = 0;
    ip_rst_n         = 1'b0;
    bus.ip_start     = 1'b0;
    bus.ip_kill      = 1'b0;
    bus.ip_funct_3   = 3'b000;
    bus.ip_operand_a = '0;
    bus.ip_operand_b = '0;
    #3;
    chk("reset busy", 64'(bus.op_busy), 64'd0);
    chk("reset done", 64'(bus.op_done), 64'd0);
    chk("reset result", 64'(bus.op_result), 64'd0);
    repeat (2) @(posedge ip_clk);
    #1;
    ip_rst_n = 1'b1;

    // First start on the first edge after reset release.
    run_op("mul 7x6", F_MUL, 32'd7, 32'd6, 32'h0000002A, 32, 0);

    run_op("mulh -1x-1", F_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32, 0);
    run_op("mulhu max", F_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32, 0);
    run_op("mulhsu -1xmax", F_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32, 0);
    run_op("mul -1x-1", F_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32, 0);
    run_op("mulh minxmin", F_MULH, 32'h80000000, 32'h80000000, 32'h40000000, 32, 0);

    run_op("div -7/2", F_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32, 0);
    run_op("rem -7/2", F_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32, 0);
    run_op("divu -7/2", F_DIVU, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32, 0);
    run_op("remu -7/2", F_REMU, 32'hFFFFFFF9, 32'd2, 32'h00000001, 32, 0);
    run_op("divu 100/7", F_DIVU, 32'd100, 32'd7, 32'd14, 32, 0);
    run_op("remu 100/7", F_REMU, 32'd100, 32'd7, 32'd2, 32, 0);

    run_op("divu 5/0", F_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 2, 0);
    run_op("rem 5/0", F_REM, 32'd5, 32'd0, 32'h00000005, 2, 0);
    run_op("div ovf", F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2, 0);
    run_op("rem ovf", F_REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2, 0);

    run_op("mul 3x3 start ignored", F_MUL, 32'd3, 32'd3, 32'd9, 32, 5);

    // kill and start together in IDLE: nothing starts
    bus.ip_start = 1'b1;
    bus.ip_kill  = 1'b1;
    step();
    bus.ip_start = 1'b0;
    bus.ip_kill  = 1'b0;
    chk("idle kill wins busy", 64'(bus.op_busy), 64'd0);

    // MUL 3x3, stray start in cycle 5, kill in cycle 10
    nd = 0;
    start_op(F_MUL, 32'd3, 32'd3);
    for (int c = 1; c < 11; c++) begin
      bus.ip_start = (c == 5);
      bus.ip_kill  = (c == 10);
      if (c == 5) begin
        bus.ip_operand_a = 32'd11;
        bus.ip_operand_b = 32'd13;
      end
      if (bus.op_done) nd++;
      step();
    end
    bus.ip_start = 1'b0;
    bus.ip_kill  = 1'b0;
    chk("kill busy", 64'(bus.op_busy), 64'd0);
    chk("kill result held", 64'(bus.op_result), 64'd9);
    for (int c = 0; c < 36; c++) begin
      if (bus.op_done) nd++;
      step();
    end
    chk("kill no done", 64'(nd), 64'd0);
    chk("kill result still held", 64'(bus.op_result), 64'd9);
    run_op("mul 2x2 after kill", F_MUL, 32'd2, 32'd2, 32'd4, 32, 0);

    // asynchronous reset mid-DIV, cycle 15, between edges
    start_op(F_DIV, 32'd100, 32'd7);
    repeat (14) step();
    #2;
    ip_rst_n = 1'b0;
    #1;
    chk("async rst busy", 64'(bus.op_busy), 64'd0);
    chk("async rst done", 64'(bus.op_done), 64'd0);
    chk("async rst result", 64'(bus.op_result), 64'd0);
    step();
    ip_rst_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.op_done || bus.op_busy) nd++;
      step();
    end
    chk("no done after reset", 64'(nd), 64'd0);
    chk("result after reset", 64'(bus.op_result), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/m_ext_unit.md
M_EXT_UNIT -- requirements
Module: m_ext_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width; only 32 SHALL be required to work.
REQ-002 The block SHALL have port ip_clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port ip_rst_n, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-004 The block SHALL have port ip_start, input, 1 bit: request pulse, driven from the decoder's M-extension write-back control.
REQ-005 The block SHALL have port ip_kill, input, 1 bit: synchronous abort from a pipeline flush.
REQ-006 The block SHALL have port ip_funct_3, input, 3 bits: operation select, 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 The block SHALL have ports ip_operand_a and ip_operand_b, input, WIDTH bits each: rs1 and rs2 values.
REQ-008 The block SHALL have port op_busy, output, 1 bit: high in every state except IDLE.
REQ-009 The block SHALL have port op_done, output, 1 bit: one-cycle pulse marking op_result valid.
REQ-010 The block SHALL have port op_result, output, WIDTH bits: registered result.

Function
REQ-011 The state machine SHALL have the states IDLE, MUL, DIV and DONE.
REQ-012 In IDLE, ip_start=1 at a rising edge SHALL capture ip_funct_3 and both operands and SHALL load an iteration counter with 0.
REQ-013 The transition taken on that start edge SHALL be: funct_3[2]=0 goes to MUL; funct_3[2]=1 goes to DIV, unless a special case from REQ-017 or REQ-018 applies.
REQ-014 MUL and DIV SHALL perform one radix-2 iteration per cycle (shift-add, restoring shift-subtract) on operand magnitudes, for exactly 32 iterations.
- The edge that performs the 32nd iteration SHALL move the state to DONE.
- op_done SHALL therefore be high in the 32nd cycle after the start edge.
REQ-015 Signedness SHALL be as follows:
- MULH, DIV and REM: both operands signed.
- MULHSU: a signed, b unsigned.
- Others: unsigned.
- Magnitudes SHALL be taken before iterating.
- The result SHALL be negated when the sign rule requires it: product sign = sign(a) XOR sign(b); quotient sign likewise; remainder sign = sign of dividend.
REQ-016 Result selection SHALL be: MUL gives product[31:0]; MULH, MULHSU and MULHU give product[63:32]; DIV and DIVU give the quotient; REM and REMU give the remainder.
REQ-017 A divisor of 0 SHALL take a fast path, going directly to DONE on the start edge's next edge (op_done in the 2nd cycle).
- DIV and DIVU SHALL give 0xFFFFFFFF.
- REM and REMU SHALL give the dividend.
REQ-018 Signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF) SHALL take the same fast path.
- DIV SHALL give 0x80000000.
- REM SHALL give 0x00000000.
REQ-019 op_result SHALL be written only on entry to DONE and SHALL hold its value until the next entry to DONE.
REQ-020 DONE SHALL last one cycle and SHALL then go to IDLE unconditionally.
REQ-021 ip_start SHALL be ignored in MUL, DIV and DONE; the operation in progress and the captured operands SHALL be unaffected.
REQ-022 ip_kill=1 at an edge in MUL or DIV SHALL return the block to IDLE with no op_done and op_result unchanged.
REQ-023 ip_kill in DONE SHALL NOT suppress the op_done pulse in progress.
REQ-024 When ip_kill and ip_start are both high in IDLE, ip_kill SHALL win and nothing SHALL start.
REQ-025 An operand change after the start edge SHALL NOT affect the result.

Reset
REQ-026 While ip_rst_n=0, asynchronously, the block SHALL be held in state IDLE with:
- op_busy=0
- op_done=0
- op_result=0x00000000
- counter=0
- all internal registers cleared
REQ-027 Reset asserted mid-operation SHALL abort the operation; no op_done SHALL follow the release of reset.
REQ-028 The first start SHALL be accepted at the first rising edge after ip_rst_n rises.

Verification
REQ-029 The bench SHALL cover MUL with a=7, b=6: required response op_busy high for 32 cycles, op_done in cycle 32, op_result=0x0000002A.
REQ-030 The bench SHALL cover a=b=0xFFFFFFFF:
- MULH gives 0x00000000.
- MULHU gives 0xFFFFFFFE.
- MULHSU gives 0xFFFFFFFF.
- MUL gives 0x00000001.
REQ-031 The bench SHALL cover a=0xFFFFFFF9 (-7), b=2:
- DIV gives 0xFFFFFFFD.
- REM gives 0xFFFFFFFF.
- DIVU gives 0x7FFFFFFC.
- REMU gives 0x00000001.
REQ-032 The bench SHALL cover the special cases, each with op_done in cycle 2:
- DIVU 5/0 gives 0xFFFFFFFF.
- REM 5/0 gives 0x00000005.
- DIV 0x80000000/0xFFFFFFFF gives 0x80000000.
- REM of the same operands gives 0x00000000.
REQ-033 The bench SHALL cover start MUL 3x3, then ip_start with new operands in cycle 5, then ip_kill pulsed in cycle 10:
- The cycle-5 ip_start is ignored.
- After the kill: IDLE, no op_done, op_result unchanged.
- A new MUL 2x2 then gives 0x00000004.
REQ-034 The bench SHALL cover ip_rst_n driven low between clock edges in cycle 15 of a DIV:
- All outputs are 0 immediately, before the next clock edge.
- No op_done follows the release of reset.
